// File: rtl/qdiv_seq.sv
// -----------------------------------------------------------------------------
// qdiv_seq: iterative restoring divider for sign-magnitude Q-format words.
//
// The dividend is normally the difference word from the fixed-point subtractor.
// The divider produces one quotient bit per cycle and has a valid/ready
// handshake on both sides. Only one transaction is in flight at a time.
//
// Parameters
//   Q   number of fractional bits
//   N   total word width (1 sign bit + N-1 magnitude bits)
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   dividend/divisor pair presented
//   in_ready   block can accept a pair (registered)
//   dividend   sign-magnitude dividend
//   divisor    sign-magnitude divisor
//   out_valid  quotient and flags valid (registered)
//   out_ready  downstream accepts the result
//   quotient   sign-magnitude quotient (registered)
//   ovf        magnitude saturated, or divide-by-zero (registered)
//   dbz        divisor magnitude was zero (registered)
//
// Optional build macro
//   QDIV_ROUND_EN  runs one extra iteration for a guard bit and rounds the
//                  magnitude half away from zero (latency +1). When the macro
//                  is undefined the magnitude is truncated toward zero.
// -----------------------------------------------------------------------------
module qdiv_seq #(
    parameter int unsigned Q = 15,
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic         ovf,
    output logic         dbz
);

    // Magnitude width.
    localparam int unsigned M  = N - 1;
`ifdef QDIV_ROUND_EN
    // One extra iteration yields the guard bit.
    localparam int unsigned G  = 1;
`else
    localparam int unsigned G  = 0;
`endif
    // Shift register / iteration count: {magnitude, Q zeros[, guard slot]}.
    localparam int unsigned SW = M + Q + G;
    localparam int unsigned CW = $clog2(SW + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic          sign_r;
    logic [M-1:0]  dvs_r;
    logic [SW-1:0] sreg;
    logic [N-1:0]  rem;
    logic [CW-1:0] cnt;

    // One restoring step. sreg shifts dividend bits out of its top and
    // quotient bits into its bottom, so after SW steps it holds the raw
    // quotient. The shifted remainder is kept one bit wider so the trial
    // compare sees every bit.
    logic [N:0]    rem_sh;
    logic          qbit;
    logic [N-1:0]  rem_nx;
    logic [SW-1:0] sreg_nx;

    always_comb begin
        rem_sh  = {rem, sreg[SW-1]};
        qbit    = (rem_sh >= {2'b00, dvs_r});
        rem_nx  = qbit ? N'(rem_sh - {2'b00, dvs_r}) : rem_sh[N-1:0];
        sreg_nx = {sreg[SW-2:0], qbit};
    end

    // Final magnitude and overflow, evaluated on the last step's result.
    logic [M-1:0] mag_fin;
    logic         ovf_fin;

`ifdef QDIV_ROUND_EN
    logic [M+Q-1:0] raw_q;
    logic [M:0]     rnd_q;

    always_comb begin
        raw_q   = sreg_nx[SW-1:1];
        rnd_q   = {1'b0, raw_q[M-1:0]} + {{M{1'b0}}, sreg_nx[0]};
        mag_fin = '0;
        ovf_fin = 1'b0;
        // Saturate on integer overflow or on a carry out of the increment.
        if ((|raw_q[M+Q-1:M]) || rnd_q[M]) begin
            mag_fin = '1;
            ovf_fin = 1'b1;
        end else begin
            mag_fin = rnd_q[M-1:0];
        end
    end
`else
    always_comb begin
        mag_fin = '0;
        ovf_fin = 1'b0;
        // Any quotient bit above the magnitude field means saturation.
        if (|sreg_nx[SW-1:M]) begin
            mag_fin = '1;
            ovf_fin = 1'b1;
        end else begin
            mag_fin = sreg_nx[M-1:0];
        end
    end
`endif

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            sign_r    <= 1'b0;
            dvs_r     <= '0;
            sreg      <= '0;
            rem       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sign_r   <= dividend[N-1] ^ divisor[N-1];
                        dvs_r    <= divisor[M-1:0];
                        in_ready <= 1'b0;
                        if (divisor[M-1:0] == '0) begin
                            // Divide-by-zero: finish immediately, saturated.
                            quotient  <= {dividend[N-1] ^ divisor[N-1], {M{1'b1}}};
                            ovf       <= 1'b1;
                            dbz       <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            sreg  <= {dividend[M-1:0], {(Q + G){1'b0}}};
                            rem   <= '0;
                            cnt   <= CW'(SW);
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    sreg <= sreg_nx;
                    rem  <= rem_nx;
                    cnt  <= cnt - CW'(1);
                    // Last step: counter about to reach zero.
                    if (cnt == CW'(1)) begin
                        // Zero magnitude never carries a negative sign.
                        quotient  <= {sign_r & (|mag_fin), mag_fin};
                        ovf       <= ovf_fin;
                        dbz       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    // Result held until downstream takes it.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdiv_seq.sv
// -----------------------------------------------------------------------------
// tb_qdiv_seq: scoreboard bench for qdiv_seq. The driver pushes the expected
// result of each accepted pair (from an arithmetic reference model) into a
// queue; an independent monitor pops and compares whenever a result appears,
// and checks that held results stay stable under backpressure.
// -----------------------------------------------------------------------------
module tb_qdiv_seq;

    localparam int unsigned Q = 15;
    localparam int unsigned N = 32;
`ifdef QDIV_ROUND_EN
    localparam int LAT = N + Q + 1;
`else
    localparam int LAT = N + Q;
`endif

    typedef struct {
        logic [31:0] q;
        logic        ovf;
        logic        dbz;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic        ovf;
    logic        dbz;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    exp_t sbq[$];

    qdiv_seq #(.Q(Q), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .ovf(ovf),
        .dbz(dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: real-valued division on magnitudes with plain integer math.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int acc);
        exp_t        r;
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] qq;
        logic        s;
        s     = a[31] ^ b[31];
        ma    = {33'd0, a[30:0]};
        mb    = {33'd0, b[30:0]};
        r.acc = acc;
        r.dbz = 1'b0;
        r.ovf = 1'b0;
        if (mb == 64'd0) begin
            r.q   = {s, 31'h7FFF_FFFF};
            r.ovf = 1'b1;
            r.dbz = 1'b1;
        end else begin
`ifdef QDIV_ROUND_EN
            qq = (ma << (Q + 1)) / mb;
            qq = (qq >> 1) + (qq & 64'd1);
`else
            qq = (ma << Q) / mb;
`endif
            if (qq > 64'h7FFF_FFFF) begin
                qq    = 64'h7FFF_FFFF;
                r.ovf = 1'b1;
            end
            r.q = {(qq != 64'd0) ? s : 1'b0, qq[30:0]};
        end
        return r;
    endfunction

    // Present one pair, waiting (bounded) for in_ready while driving noise.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 400) begin
            in_valid = 1'($urandom_range(0, 1));
            dividend = $urandom;
            divisor  = $urandom;
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            dividend = a;
            divisor  = b;
            in_valid = 1'b1;
            sbq.push_back(model(a, b, cyc));
            @(negedge clk);
            in_valid = 1'b0;
            dividend = $urandom;
            divisor  = $urandom;
        end
    endtask

    // Wait (bounded) until every expected result has been delivered.
    task automatic drain();
        int t;
        t = 0;
        while ((sbq.size() != 0 || out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
    endtask

    // Monitor: compare each new result, check stability while it is held.
    initial begin : monitor
        exp_t        e;
        logic        active;
        logic [31:0] hq;
        logic        ho;
        logic        hd;
        active = 1'b0;
        hq = '0;
        ho = 1'b0;
        hd = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active    = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (out_valid && !active) begin
                    active = 1'b1;
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %0h expected none", quotient);
                    end else begin
                        e = sbq.pop_front();
                        chk("quotient", 64'(quotient), 64'(e.q));
                        chk("ovf", 64'(ovf), 64'(e.ovf));
                        chk("dbz", 64'(dbz), 64'(e.dbz));
                        chk("latency", 64'(cyc - e.acc), e.dbz ? 64'd1 : 64'(LAT));
                        chk("in_ready_done", 64'(in_ready), 64'd0);
                    end
                    hq = quotient;
                    ho = ovf;
                    hd = dbz;
                end else if (out_valid) begin
                    chk("hold_quotient", 64'(quotient), 64'(hq));
                    chk("hold_ovf", 64'(ovf), 64'(ho));
                    chk("hold_dbz", 64'(dbz), 64'(hd));
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                end else begin
                    active = 1'b0;
                end
                case (rdy_mode)
                    1:       out_ready = 1'b0;
                    2:       out_ready = 1'b1;
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
            end
        end
    end

    initial begin : stim
        logic [31:0] a;
        logic [31:0] b;
        int          t;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_dbz", 64'(dbz), 64'd0);
        rst = 1'b0;

        // Directed cases.
        send(32'h0001_8000, 32'h0001_0000);
        send(32'h8001_8000, 32'h0001_0000);
        send(32'h8000_0000, 32'h0000_8000);
        send(32'h0000_8000, 32'h8000_0000);
        send(32'h4000_0000, 32'h0000_0001);
        send(32'h0000_0001, 32'h0001_0000);
        send(32'h8000_0001, 32'h0001_0000);
        send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        drain();

        // Backpressure: result held 5 cycles while another pair is offered.
        rdy_mode = 1;
        send(32'h0003_0000, 32'h8000_4000);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        dividend = 32'h0001_0000;
        divisor  = 32'h0000_0000;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset in the middle of BUSY: in-flight result is discarded.
        send(32'h0001_8000, 32'h0001_0000);
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        if (sbq.size() != 0) void'(sbq.pop_back());
        @(negedge clk);
        rst = 1'b0;
        send(32'h0004_8000, 32'h0001_8000);
        drain();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            a[30:0] = a[30:0] >> $urandom_range(0, 30);
            b[30:0] = b[30:0] >> $urandom_range(0, 30);
            if ($urandom_range(0, 15) == 0) b[30:0] = '0;
            send(a, b);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qdiv_seq.md
Name: qdiv_seq

Overview:
- Iterative fixed-point divider for the sign-magnitude Q-format datapath: bit N-1 is the sign, bits N-2:0 are the magnitude, and Q is the number of fractional bits.
- Sits directly downstream of the fixed-point subtractor. It takes the subtractor's difference word as dividend and a second sign-magnitude operand as divisor.
- Produces one quotient per request using a restoring one-bit-per-cycle algorithm, with a valid/ready handshake on both sides.

Parameters:
- Q, 15, number of fractional bits.
- N, 32, total word width (1 sign bit + N-1 magnitude bits).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  dividend/divisor pair presented.
- in_ready  output  1  block can accept a pair.
- dividend  input  N  sign-magnitude dividend.
- divisor  input  N  sign-magnitude divisor.
- out_valid  output  1  quotient and flags valid.
- out_ready  input  1  downstream accepts the result.
- quotient  output  N  sign-magnitude result.
- ovf  output  1  magnitude saturated; also set on divide-by-zero.
- dbz  output  1  divisor magnitude was zero.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, quotient=0, ovf=0, dbz=0, all internal registers cleared. A transaction in flight is discarded and nothing is emitted.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, capture sign_r = dividend[N-1]^divisor[N-1], the dividend magnitude and the divisor magnitude.
  - If the divisor magnitude is 0, go to DONE with quotient={sign_r, all ones}, ovf=1, dbz=1.
  - Otherwise go to BUSY: load the shift register with {dividend magnitude, Q zeros} (N-1+Q bits), clear the remainder (N bits), set counter=N-1+Q.
- BUSY: in_ready=0. Each cycle:
  - Shift the next dividend bit into the remainder.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and shift a quotient bit of 1; otherwise shift a 0.
  - Decrement the counter. When it reaches 0, go to DONE.
  - Latency from accept to out_valid: N-1+Q+1 cycles (47 at defaults). Divide-by-zero: 1 cycle.
- DONE entry:
  - If any raw quotient bit above N-2 is set, saturate: magnitude=all ones, ovf=1.
  - Otherwise magnitude = the low N-1 quotient bits, ovf=0.
  - A zero magnitude forces the sign bit to 0 (no negative zero is emitted).
- DONE: out_valid=1, in_ready=0. quotient, ovf and dbz are held stable until out_ready=1. On that handshake cycle, return to IDLE with out_valid=0.
- No overlap between transactions: a new pair is accepted earliest on the cycle after the output handshake.
- Inputs are sampled only on the accept cycle. in_valid and operand changes during BUSY or DONE are ignored.
- Rounding is truncation toward zero (magnitude truncation).

Optional Feature:
- Macro: QDIV_ROUND_EN.
- Defined:
  - One extra iteration produces a guard bit; latency grows by 1 (48 at defaults).
  - If the guard bit is 1, increment the magnitude (round half away from zero).
  - If the increment carries past N-1 bits, saturate and set ovf=1.
- Undefined: truncation as described in Behaviour, with no extra cycle.

Test Plan:
- dividend=0x00018000 (3.0), divisor=0x00010000 (2.0) -> quotient=0x0000C000, ovf=0, dbz=0. out_valid rises exactly 47 cycles after accept.
- dividend=0x80018000 (-3.0), divisor=0x00010000 -> quotient=0x8000C000. dividend=0x80000000, divisor=0x00008000 -> quotient=0x00000000 (sign cleared).
- dividend=0x00008000, divisor=0x80000000 (-0) -> out_valid 1 cycle after accept, quotient=0xFFFFFFFF, ovf=1, dbz=1.
- dividend=0x40000000, divisor=0x00000001 -> quotient=0x7FFFFFFF, ovf=1, dbz=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> quotient and flags stable and in_ready=0 throughout; a pair presented meanwhile is not accepted. Assert rst at cycle 20 of BUSY -> out_valid=0 and in_ready=1 immediately; the next transaction completes correctly.
- dividend=0x00000001, divisor=0x00010000 -> quotient=0x00000000 without QDIV_ROUND_EN; quotient=0x00000001 with it (latency 48).
